// File: rtl/fu_complete_arbiter_pkg.sv
// Types shared between the functional units and the writeback-side complete arbiter.
// fu_complete_t is the complete packet every FU presents on its fu_interface complete side.
package rv32i_types;

    typedef struct packed {
        logic [63:0] order;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] pc_wdata;
    } fu_complete_t;

    localparam int FU_IDX_ALU = 0;
    localparam int FU_IDX_MUL = 1;
    localparam int FU_IDX_LSU = 2;
    localparam int FU_IDX_BR  = 3;
    localparam int FU_COUNT   = 4;

endpackage

// File: rtl/fu_complete_arbiter_oldest_select.sv
// fu_oldest_select: combinational pick of the valid entry with the smallest order.
// Equal orders resolve to the lowest index; grant is one-hot, or all-zero when nothing is valid.
module fu_oldest_select #(
    parameter int NUM_FU = 4,
    parameter int IDX_W  = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0] valid,
    input  logic [63:0]       order [NUM_FU],
    output logic [NUM_FU-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    logic [63:0] best;

    // Strict less-than keeps the earlier (lower-index) entry on a tie.
    always_comb begin
        any   = 1'b0;
        idx   = '0;
        best  = '0;
        grant = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (valid[i] && (!any || (order[i] < best))) begin
                any  = 1'b1;
                idx  = IDX_W'(i);
                best = order[i];
            end
        end
        grant[idx] = any;
    end

endmodule

// File: rtl/fu_complete_arbiter.sv
// Shares the single writeback/complete port among NUM_FU functional units, oldest order first,
// through a one-entry output register. Optional stats counters under FU_ARB_STATS_EN.
module fu_complete_arbiter
    import rv32i_types::*;
#(
    parameter int  NUM_FU = 4,
    localparam int IDX_W  = $clog2(NUM_FU)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [NUM_FU-1:0] req_valid,
    input  fu_complete_t      req_data [NUM_FU],
    output logic [NUM_FU-1:0] req_ready,
    output logic              wb_valid,
    output fu_complete_t      wb_data,
    output logic [IDX_W-1:0]  wb_src,
    input  logic              wb_ready
`ifdef FU_ARB_STATS_EN
    ,
    output logic [31:0]       conflict_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    logic [63:0]       req_order [NUM_FU];
    logic [NUM_FU-1:0] sel_grant;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_any;
    logic              can_load;
    logic              grant_en;
    logic              xfer;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            req_order[i] = req_data[i].order;
        end
    end

    fu_oldest_select #(
        .NUM_FU (NUM_FU),
        .IDX_W  (IDX_W)
    ) u_select (
        .valid (req_valid),
        .order (req_order),
        .grant (sel_grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    assign can_load  = !wb_valid || wb_ready;
    assign grant_en  = can_load && !flush && !rst;
    assign req_ready = grant_en ? sel_grant : '0;
    assign xfer      = grant_en && sel_any;

    // Flush drops the held packet; a transfer overwrites a consumed one with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_src   <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (xfer) begin
            wb_valid <= 1'b1;
            wb_data  <= req_data[sel_idx];
            wb_src   <= sel_idx;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

`ifdef FU_ARB_STATS_EN
    logic conflict_hit;
    logic stall_hit;

    assign conflict_hit = ($countones(req_valid) >= 2) && !flush;
    assign stall_hit    = wb_valid && !wb_ready;

    // Saturating counters; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (conflict_hit && (conflict_cnt != 32'hFFFF_FFFF)) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
            if (stall_hit && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Self-checking bench for fu_complete_arbiter: grant vectors, directed corner sequences and
// a randomized run against a queue-based reference model. Stats checks need FU_ARB_STATS_EN.
module tb_fu_complete_arbiter;
    import rv32i_types::*;

    localparam int NUM_FU = 4;
    localparam int IDX_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [NUM_FU-1:0] req_valid;
    fu_complete_t      req_data [NUM_FU];
    logic [NUM_FU-1:0] req_ready;
    logic              wb_valid;
    fu_complete_t      wb_data;
    logic [IDX_W-1:0]  wb_src;
    logic              wb_ready;
`ifdef FU_ARB_STATS_EN
    logic [31:0]       conflict_cnt;
    logic [31:0]       stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fu_complete_arbiter #(.NUM_FU(NUM_FU)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_src    (wb_src),
        .wb_ready  (wb_ready)
`ifdef FU_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_pkt(input string name, input fu_complete_t act, input fu_complete_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic fu_complete_t mk_pkt(input logic [63:0] ord, input int src);
        fu_complete_t p;
        p.order    = ord;
        p.rd       = 5'(src * 7 + int'(ord[2:0]));
        p.data     = 32'hD000_0000 ^ ord[31:0] ^ (32'(src) << 20);
        p.pc       = 32'h8000_0000 + (ord[31:0] << 2);
        p.pc_wdata = p.pc + 32'd4;
        return p;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [63:0] ord [4];
        logic [3:0]  exp_ready;
        int          exp_src;
    } vec_t;

    function automatic vec_t mkv(input logic [3:0] v, input logic [63:0] o0, input logic [63:0] o1,
                                 input logic [63:0] o2, input logic [63:0] o3,
                                 input logic [3:0] er, input int es);
        vec_t t;
        t.valid = v;
        t.ord[0] = o0; t.ord[1] = o1; t.ord[2] = o2; t.ord[3] = o3;
        t.exp_ready = er;
        t.exp_src = es;
        return t;
    endfunction

    vec_t vec [8];

    // Reference model state for the randomized phase
    logic         m_valid;
    fu_complete_t m_data;
    int           m_src;
    logic         pend [NUM_FU];
    fu_complete_t pkt  [NUM_FU];
    logic [63:0]  order_ctr;
`ifdef FU_ARB_STATS_EN
    longint       m_conf;
    longint       m_stall;
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; wb_ready = 1'b0; req_valid = '0;
        for (int f = 0; f < NUM_FU; f++) req_data[f] = mk_pkt(64'(f + 1), f);

        // Reset state, with requests asserted to confirm rst gates the grant
        next();
        next();
        req_valid = 4'hF;
        #2;
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_src", wb_src, 0);
        chk_pkt("rst_wb_data", wb_data, '0);
`ifdef FU_ARB_STATS_EN
        chk("rst_conflict", conflict_cnt, 0);
        chk("rst_stall", stall_cnt, 0);
`endif
        next();
        req_valid = '0;
        rst = 1'b0;
        wb_ready = 1'b1;
        next();

        // Grant vectors from an empty output register
        vec[0] = mkv(4'b0100, 0, 0, 7, 0, 4'b0100, 2);
        vec[1] = mkv(4'b1011, 12, 9, 0, 10, 4'b0010, 1);
        vec[2] = mkv(4'b0110, 0, 5, 5, 0, 4'b0010, 1);
        vec[3] = mkv(4'b1111, 3, 8, 2, 2, 4'b0100, 2);
        vec[4] = mkv(4'b1000, 1, 1, 1, 100, 4'b1000, 3);
        vec[5] = mkv(4'b0000, 4, 3, 2, 1, 4'b0000, 0);
        vec[6] = mkv(4'b1001, 64'hFFFF_FFFF_0000_0000, 0, 0, 64'h1_0000_0000, 4'b1000, 3);
        vec[7] = mkv(4'b0011, 0, 1, 0, 0, 4'b0001, 0);
        for (int i = 0; i < 8; i++) begin
            req_valid = vec[i].valid;
            for (int f = 0; f < NUM_FU; f++) req_data[f] = mk_pkt(vec[i].ord[f], f);
            #2;
            chk("vec_ready", req_ready, vec[i].exp_ready);
            next();
            req_valid = '0;
            #2;
            chk("vec_wb_valid", wb_valid, vec[i].valid != 0);
            if (vec[i].valid != 0) begin
                chk("vec_wb_src", wb_src, vec[i].exp_src);
                chk_pkt("vec_wb_data", wb_data, mk_pkt(vec[i].ord[vec[i].exp_src], vec[i].exp_src));
            end
            next();
        end

        // Fresh reset so the stats counters start from zero
        rst = 1'b1;
        next();
        rst = 1'b0;

        // Oldest-first over consecutive cycles
        req_data[0] = mk_pkt(12, 0);
        req_data[1] = mk_pkt(9, 1);
        req_data[3] = mk_pkt(10, 3);
        req_valid = 4'b1011;
        #2;
        chk("old_c1_ready", req_ready, 4'b0010);
        next();
        req_valid = 4'b1001;
        #2;
        chk("old_c2_wb_order", wb_data.order, 9);
        chk("old_c2_wb_src", wb_src, 1);
        chk("old_c2_ready", req_ready, 4'b1000);
        next();
        req_valid = 4'b0001;
        #2;
        chk("old_c3_wb_order", wb_data.order, 10);
        chk("old_c3_wb_src", wb_src, 3);
        chk("old_c3_ready", req_ready, 4'b0001);
`ifdef FU_ARB_STATS_EN
        chk("old_conflict", conflict_cnt, 2);
`endif
        next();

        // Backpressure: 3 stalled cycles with FU0 requesting
        req_data[0] = mk_pkt(20, 0);
        req_valid = 4'b0001;
        wb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("bp_ready", req_ready, 4'b0000);
            chk("bp_wb_valid", wb_valid, 1'b1);
            chk_pkt("bp_wb_data", wb_data, mk_pkt(12, 0));
            chk("bp_wb_src", wb_src, 0);
            next();
        end
        wb_ready = 1'b1;
        #2;
        chk("bp_release_ready", req_ready, 4'b0001);
`ifdef FU_ARB_STATS_EN
        chk("bp_stall", stall_cnt, 3);
`endif
        next();

        // Flush with a held packet and FU2 requesting
        req_data[2] = mk_pkt(30, 2);
        req_valid = 4'b0100;
        flush = 1'b1;
        #2;
        chk_pkt("fl_wb_data", wb_data, mk_pkt(20, 0));
        chk("fl_ready", req_ready, 4'b0000);
        next();
        flush = 1'b0;
        #2;
        chk("fl_wb_valid", wb_valid, 1'b0);
        chk("fl_after_ready", req_ready, 4'b0100);
        next();

        // Reset while a packet is being granted
        req_data[1] = mk_pkt(40, 1);
        req_valid = 4'b0010;
        rst = 1'b1;
        #2;
        chk("rs_wb_order", wb_data.order, 30);
        chk("rs_wb_src", wb_src, 2);
        chk("rs_ready", req_ready, 4'b0000);
        next();
        rst = 1'b0;
        req_valid = '0;
        flush = 1'b1;
        #2;
        chk("rs_wb_valid", wb_valid, 1'b0);
        chk("rs_wb_src0", wb_src, 0);
        chk_pkt("rs_wb_data0", wb_data, '0);
`ifdef FU_ARB_STATS_EN
        chk("rs_conflict", conflict_cnt, 0);
        chk("rs_stall", stall_cnt, 0);
`endif
        next();
        flush = 1'b0;
        #2;
        chk("rs_flush_wb_valid", wb_valid, 1'b0);
        next();

        // Randomized run against the reference model
        m_valid = 1'b0;
        m_data = '0;
        m_src = 0;
        order_ctr = 64'd1000;
        for (int f = 0; f < NUM_FU; f++) pend[f] = 1'b0;
`ifdef FU_ARB_STATS_EN
        m_conf = 0;
        m_stall = 0;
`endif
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [63:0] ords [$];
            logic [63:0] mins [$];
            int          g;
            int          nreq;
            logic        load_ok;

            rst = (cyc == 0) || ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 15) == 0);
            wb_ready = ($urandom_range(0, 9) < 7);
            for (int f = 0; f < NUM_FU; f++) begin
                if (!pend[f] && ($urandom_range(0, 9) < 4)) begin
                    pend[f] = 1'b1;
                    pkt[f] = mk_pkt(order_ctr, f);
                    order_ctr = order_ctr + 64'($urandom_range(1, 3));
                end
                req_valid[f] = pend[f];
                req_data[f] = pend[f] ? pkt[f] : mk_pkt(64'($urandom), f);
            end
            #2;

            nreq = 0;
            ords.delete();
            for (int f = 0; f < NUM_FU; f++) begin
                if (pend[f]) begin
                    ords.push_back(pkt[f].order);
                    nreq++;
                end
            end
            g = -1;
            load_ok = !rst && !flush && (!m_valid || wb_ready);
            if (load_ok && (nreq > 0)) begin
                mins = ords.min();
                for (int f = NUM_FU - 1; f >= 0; f--) begin
                    if (pend[f] && (pkt[f].order == mins[0])) g = f;
                end
            end

            chk("rnd_ready", req_ready, (g >= 0) ? (4'b0001 << g) : 4'b0000);
            chk("rnd_wb_valid", wb_valid, m_valid);
            if (m_valid) begin
                chk("rnd_wb_src", wb_src, m_src);
                chk_pkt("rnd_wb_data", wb_data, m_data);
            end
`ifdef FU_ARB_STATS_EN
            chk("rnd_conflict", conflict_cnt, m_conf);
            chk("rnd_stall", stall_cnt, m_stall);
`endif
            next();

            if (rst) begin
                m_valid = 1'b0;
                m_data = '0;
                m_src = 0;
`ifdef FU_ARB_STATS_EN
                m_conf = 0;
                m_stall = 0;
`endif
            end else begin
`ifdef FU_ARB_STATS_EN
                if ((nreq >= 2) && !flush) m_conf++;
                if (m_valid && !wb_ready) m_stall++;
`endif
                if (flush) begin
                    m_valid = 1'b0;
                end else if (g >= 0) begin
                    m_valid = 1'b1;
                    m_data = pkt[g];
                    m_src = g;
                    pend[g] = 1'b0;
                end else if (wb_ready) begin
                    m_valid = 1'b0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
